router_nxn_core: RTL
====================

// Module: router_nxn_core
// PURPOSE
//  Parametrised NxN packet router core. Successor to the fixed 4x4 router, generalised in
//  port count, data width and buffer depth, with store-and-forward buffering and CSR statistics.
//  Each input port feeds a packet FIFO; per-output round-robin arbiters stream whole packets to da.
//  Sits between the sa/da port drivers and the CSR (wr/rd/addr/wdata/rdata) host bus.
// PARAMETERS
//  NUM_PORTS   4   input and output port count (2..16)
//  DATA_W      8   byte-lane width of sa/da (>=8; header fields use bits [7:0])
//  FIFO_DEPTH  64  entries per input FIFO; power of 2; packets longer than FIFO_DEPTH are always dropped
// PORTS
//  clk       in   1                 single clock, all logic on posedge
//  reset     in   1                 synchronous, active-high
//  sa        in   NUM_PORTS*DATA_W  input byte per port; port i at [i*DATA_W +: DATA_W]
//  sa_valid  in   NUM_PORTS         sa byte qualifier per port; gaps allowed inside a packet
//  da        out  NUM_PORTS*DATA_W  output byte per port
//  da_valid  out  NUM_PORTS         da byte qualifier; contiguous for a whole packet
//  wr        in   1                 CSR write strobe
//  rd        in   1                 CSR read strobe
//  addr      in   8                 CSR byte address, word-aligned
//  wdata     in   32                CSR write data
//  rdata     out  32                CSR read data
// BEHAVIOUR
//  Packet: byte0 = dest port (bits [3:0]); byte1 = payload length L (0..255); then L payload bytes. Total L+2 bytes.
//  Reset: da=0, da_valid=0, rdata=0; all FIFOs empty; parsers IDLE; CTRL=1; PORT_EN = all ones; counters 0.
//  Input parser FSM per port: IDLE -> (valid byte) LEN -> (valid byte) PAYLOAD[L] -> IDLE; if L=0, LEN -> IDLE.
//   - Enable (CTRL[0] & PORT_EN[i]) is sampled only on the header byte; if disabled, the whole packet is
//     consumed and discarded (no FIFO write, no drop count).
//   - FIFO holds wr_ptr and commit_ptr. Bytes are written at wr_ptr; commit_ptr <= wr_ptr on the last byte.
//   - A byte arriving when the FIFO is full, or dest >= NUM_PORTS: wr_ptr rolls back to commit_ptr, the rest of
//     the packet is discarded, DROP_CNT[i] += 1 (once per packet).
//  Output side: input i is eligible for output o when committed data exists and its head byte (dest) == o.
//   - Round-robin per output; pointer starts at input 0, then advances to (grant+1) mod NUM_PORTS after each packet.
//   - Grant is held until the last byte; one byte per cycle, da_valid held high for L+2 cycles, no bubbles.
//   - Latency: last input byte on cycle t -> first da_valid no earlier than t+2 (uncontended).
//   - Different outputs stream in parallel; an input serves only one output at a time.
//   - The same-cycle FIFO read of byte k and write into the freed slot is legal.
//  CSR: write takes effect the next cycle; rd -> rdata valid the next cycle, held until the next rd.
//   Unmapped read returns 0.
//   0x00 CTRL[0] global enable; 0x04 PORT_EN[NUM_PORTS-1:0]; 0x08+4*i DROP_CNT[i] (32b, wraps).
//  A write to any counter clears it; a clear and an increment in the same cycle -> clear wins (value 0).
//  Reset mid-packet: everything is flushed; da_valid=0 the cycle after reset is sampled, and partial packets are lost.
// CONFIGURATION
//  ROUTER_STATS_EN defined: 0x80+4*i TX_PKT_CNT[i] (+1 when the last byte of a packet leaves output i) and
//   0xC0+4*i RX_BYTE_CNT[i] (+1 per committed input byte, added at commit); clear-on-write, clear wins.
//  ROUTER_STATS_EN undefined: these counters are not built; reads of 0x80..0xFF return 0; writes are ignored.
// STRUCTURE
//  router_pkg: parse_state_e {IDLE,LEN,PAYLOAD}, CSR address localparams, HDR_DEST_W=4, LEN_W=8.
//  Sub-module router_in_fifo: per-port commit/rollback FIFO, instantiated NUM_PORTS times;
//   the arbiter and CSR logic stay in the top.
// TESTING
//  1. Port0 sends dest=2, L=3 {AA,BB,CC} -> da[2] outputs 02,03,AA,BB,CC on 5 consecutive cycles; other outputs idle.
//  2. Ports 0,1,3 all send dest=1, L=1 on the same cycle -> da[1] delivers the 0,1,3 packets in that order, back-to-back.
//  3. FIFO_DEPTH=64, port2 sends L=70 -> nothing on any output; DROP_CNT[2]=1; a following L=4 packet is delivered intact.
//  4. dest=9 with NUM_PORTS=4 -> packet dropped, DROP_CNT[i]=1; write 0 to 0x08+4*i on the increment cycle -> reads 0.
//  5. Write PORT_EN=4'b1110, port0 sends a packet -> no output, DROP_CNT[0]=0; port1 is still routed.
//  6. Assert reset in the middle of an 8-byte output stream -> da_valid=0 the next cycle; FIFOs empty; CSRs read reset values.
//     With ROUTER_STATS_EN, TX_PKT_CNT=0 after reset.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg
//   Shared types and constants for the NxN store-and-forward router:
//   input parser states, packet header field widths and CSR byte addresses.
package router_pkg;

    localparam int HDR_DEST_W = 4;   // destination port field in header byte 0
    localparam int LEN_W      = 8;   // payload length field in header byte 1

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD
    } parse_state_e;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_PORT_EN   = 8'h04;
    localparam logic [7:0] ADDR_DROP_BASE = 8'h08;
    localparam logic [7:0] ADDR_TX_BASE   = 8'h80;
    localparam logic [7:0] ADDR_RX_BASE   = 8'hC0;

endpackage

// File: rtl/router_in_fifo.sv
// router_in_fifo
//   Per-input-port packet parser plus commit/rollback FIFO. Bytes of a packet
//   are written speculatively at wr_ptr; only when the last byte lands does
//   commit_ptr move, so the output side never sees a partial packet. A packet
//   that overflows the FIFO or names a non-existent destination is rolled back
//   and the remainder of it is swallowed.
// Ports
//   clk, reset       clock, synchronous active-high reset
//   en_i             port enable, sampled on the header byte only
//   in_data_i        input byte, in_valid_i qualifies it
//   rd_en_i          pop one committed byte
//   head_o, avail_o  byte at the read pointer / committed data present
//   drop_o           one-cycle pulse, once per dropped packet
//   commit_o         one-cycle pulse when a packet is committed
//   commit_len_o     byte count of the packet being committed
module router_in_fifo
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en_i,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic                          in_valid_i,
    input  logic                          rd_en_i,
    output logic [DATA_W-1:0]             head_o,
    output logic                          avail_o,
    output logic                          drop_o,
    output logic                          commit_o,
    output logic [$clog2(FIFO_DEPTH):0]   commit_len_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    ptr_t              wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q;
    parse_state_e      state_q, state_d;
    logic              keep_q, keep_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              we, hdr, wanted, bad, full, last;
    logic [LEN_W-1:0]  byte_v;

    always_comb begin
        byte_v   = in_data_i[LEN_W-1:0];
        hdr      = (state_q == IDLE);
        // A pop in the same cycle frees a slot, so the write may proceed.
        full     = ((wr_ptr_q - rd_ptr_q) == ptr_t'(FIFO_DEPTH)) && !rd_en_i;
        bad      = hdr && (32'(in_data_i[HDR_DEST_W-1:0]) >= NUM_PORTS);
        wanted   = hdr ? en_i : keep_q;
        last     = ((state_q == LEN) && (byte_v == '0)) ||
                   ((state_q == PAYLOAD) && (rem_q == LEN_W'(1)));
        state_d  = state_q;
        keep_d   = keep_q;
        rem_d    = rem_q;
        wr_ptr_d = wr_ptr_q;
        commit_d = commit_q;
        we       = 1'b0;
        drop_o   = 1'b0;
        commit_o = 1'b0;
        commit_len_o = wr_ptr_q + ptr_t'(1) - commit_q;

        if (in_valid_i) begin
            case (state_q)
                IDLE:    state_d = LEN;
                LEN: begin
                    rem_d   = byte_v;
                    state_d = (byte_v == '0) ? IDLE : PAYLOAD;
                end
                PAYLOAD: begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // keep stays low for the rest of a discarded or dropped packet.
            keep_d = 1'b0;
            if (wanted) begin
                if (bad || full) begin
                    drop_o   = 1'b1;
                    wr_ptr_d = commit_q;
                end else begin
                    keep_d   = 1'b1;
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + ptr_t'(1);
                    if (last) begin
                        commit_d = wr_ptr_q + ptr_t'(1);
                        commit_o = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            keep_q   <= 1'b0;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            commit_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            keep_q   <= keep_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
            rd_ptr_q <= rd_ptr_q + ptr_t'(rd_en_i);
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign avail_o = (commit_q != rd_ptr_q);

endmodule

// File: rtl/router_nxn_core.sv
// router_nxn_core
//   NxN store-and-forward packet router. Each input has a router_in_fifo;
//   each output has a round-robin arbiter that streams one whole committed
//   packet (dest, len, payload) per grant with no bubbles. CSR block holds
//   global/port enables and per-port drop counters.
//   Optional macro ROUTER_STATS_EN adds TX_PKT_CNT (0x80+4i) and
//   RX_BYTE_CNT (0xC0+4i); without it that range reads 0 and ignores writes.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   sa, sa_valid      input byte / qualifier per port (port i at [i*DATA_W +: DATA_W])
//   da, da_valid      output byte / qualifier per port
//   wr, rd, addr      CSR strobes and byte address
//   wdata, rdata      CSR write data / registered read data
module router_nxn_core
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*DATA_W-1:0]   sa,
    input  logic [NUM_PORTS-1:0]          sa_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   da,
    output logic [NUM_PORTS-1:0]          da_valid,
    input  logic                          wr,
    input  logic                          rd,
    input  logic [7:0]                    addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]                head [NUM_PORTS];
    logic [NUM_PORTS-1:0]             avail, drop, commit, rd_en, in_busy, tx_done;
    logic [NUM_PORTS-1:0][CW-1:0]     commit_len;

    logic                             ctrl_q;
    logic [NUM_PORTS-1:0]             port_en_q;
    logic [NUM_PORTS-1:0][31:0]       drop_cnt_q;
    logic [31:0]                      rdata_q, rd_val;

    logic [NUM_PORTS-1:0]             busy_q, busy_d, hdr_q, hdr_d, dav_q, dav_d;
    logic [NUM_PORTS-1:0][LEN_W-1:0]  rem_q, rem_d;
    logic [NUM_PORTS-1:0][IDX_W-1:0]  gnt_q, gnt_d, rr_q, rr_d;
    logic [NUM_PORTS*DATA_W-1:0]      da_q, da_d;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        router_in_fifo #(
            .NUM_PORTS (NUM_PORTS),
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .en_i        (ctrl_q & port_en_q[i]),
            .in_data_i   (sa[i*DATA_W +: DATA_W]),
            .in_valid_i  (sa_valid[i]),
            .rd_en_i     (rd_en[i]),
            .head_o      (head[i]),
            .avail_o     (avail[i]),
            .drop_o      (drop[i]),
            .commit_o    (commit[i]),
            .commit_len_o(commit_len[i])
        );
    end

    always_comb begin : arb
        logic [IDX_W-1:0] sel;
        logic             found, lst;
        logic [LEN_W-1:0] b;
        int               idx;
        busy_d  = busy_q;
        hdr_d   = hdr_q;
        rem_d   = rem_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        rd_en   = '0;
        tx_done = '0;
        da_d    = '0;
        dav_d   = '0;
        in_busy = '0;
        sel     = '0;
        found   = 1'b0;
        lst     = 1'b0;
        b       = '0;
        idx     = 0;
        // An input being streamed exposes payload bytes at its head; they must
        // not be mistaken for a header by another output.
        for (int o = 0; o < NUM_PORTS; o++)
            if (busy_q[o]) in_busy[gnt_q[o]] = 1'b1;
        for (int o = 0; o < NUM_PORTS; o++) begin
            sel   = gnt_q[o];
            found = 1'b0;
            lst   = 1'b0;
            if (!busy_q[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (!found && avail[idx] && !in_busy[idx] &&
                        int'(head[idx][HDR_DEST_W-1:0]) == o) begin
                        found = 1'b1;
                        sel   = IDX_W'(idx);
                    end
                end
            end
            b = head[sel][LEN_W-1:0];
            if (busy_q[o] || found) begin
                rd_en[sel]                = 1'b1;
                da_d[o*DATA_W +: DATA_W]  = head[sel];
                dav_d[o]                  = 1'b1;
                if (!busy_q[o]) begin
                    busy_d[o] = 1'b1;
                    hdr_d[o]  = 1'b1;
                    gnt_d[o]  = sel;
                end else if (hdr_q[o]) begin
                    rem_d[o] = b;
                    hdr_d[o] = 1'b0;
                    lst      = (b == '0);
                end else begin
                    rem_d[o] = rem_q[o] - LEN_W'(1);
                    lst      = (rem_q[o] == LEN_W'(1));
                end
                if (lst) begin
                    busy_d[o]  = 1'b0;
                    rr_d[o]    = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + IDX_W'(1);
                    tx_done[o] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            hdr_q  <= '0;
            rem_q  <= '0;
            gnt_q  <= '0;
            rr_q   <= '0;
            da_q   <= '0;
            dav_q  <= '0;
        end else begin
            busy_q <= busy_d;
            hdr_q  <= hdr_d;
            rem_q  <= rem_d;
            gnt_q  <= gnt_d;
            rr_q   <= rr_d;
            da_q   <= da_d;
            dav_q  <= dav_d;
        end
    end

    assign da       = da_q;
    assign da_valid = dav_q;

`ifdef ROUTER_STATS_EN
    logic [NUM_PORTS-1:0][31:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (wr && addr == ADDR_TX_BASE + 8'(4*i))      tx_cnt_q[i] <= '0;
                else if (tx_done[i])                           tx_cnt_q[i] <= tx_cnt_q[i] + 32'd1;
                if (wr && addr == ADDR_RX_BASE + 8'(4*i))      rx_cnt_q[i] <= '0;
                else if (commit[i])                            rx_cnt_q[i] <= rx_cnt_q[i] + 32'(commit_len[i]);
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{commit, commit_len, tx_done};
`endif

    always_comb begin
        rd_val = '0;
        if (addr == ADDR_CTRL)    rd_val = {31'b0, ctrl_q};
        if (addr == ADDR_PORT_EN) rd_val = 32'(port_en_q);
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr == ADDR_DROP_BASE + 8'(4*i)) rd_val = drop_cnt_q[i];
`ifdef ROUTER_STATS_EN
            if (addr == ADDR_TX_BASE + 8'(4*i))   rd_val = tx_cnt_q[i];
            if (addr == ADDR_RX_BASE + 8'(4*i))   rd_val = rx_cnt_q[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 1'b1;
            port_en_q  <= '1;
            drop_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (wr && addr == ADDR_CTRL)    ctrl_q    <= wdata[0];
            if (wr && addr == ADDR_PORT_EN) port_en_q <= wdata[NUM_PORTS-1:0];
            // A clear landing on the same cycle as a drop leaves the counter at 0.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (wr && addr == ADDR_DROP_BASE + 8'(4*i)) drop_cnt_q[i] <= '0;
                else if (drop[i])                           drop_cnt_q[i] <= drop_cnt_q[i] + 32'd1;
            end
            if (rd) rdata_q <= rd_val;
        end
    end

    assign rdata = rdata_q;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:NUM_PORTS];

endmodule
